// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. The frame format is configurable: 5-9 data
//   bits, optional odd/even parity, and 1 or 2 stop bits. The rx input passes
//   through a 2-flop synchroniser. Each bit is decided by a 3-tap majority
//   vote around mid-bit, using an oversampling tick. Received words go to the
//   consumer over a valid/ready handshake and carry per-word parity, framing
//   and overrun status.
//
// Parameters
//   CLK_FREQ    system clock frequency, Hz
//   BAUD_RATE   line rate, bit/s
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 none, 1 odd, 2 even
//   STOP_BITS   1 or 2
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   data_out     received word, LSB = first bit on the line
//   data_valid   word available; held until accepted
//   data_ready   consumer accepts the word when valid & ready at a clock edge
//   parity_err   parity mismatch for the word in data_out
//   framing_err  a stop bit was sampled 0 for the word in data_out
//   overrun_err  1-cycle pulse: an unaccepted word was overwritten
//   break_det    1-cycle pulse on a line break (tied 0 unless enabled)
//   busy         receiver FSM is not idle
//
// Build option
//   UART_RX_BREAK_DETECT_EN  When defined, a frame whose data, parity and
//                            stop votes are all 0 pulses break_det and is not
//                            delivered. When undefined, that frame is
//                            delivered as data 0 with framing_err set. In both
//                            builds the receiver waits for the line to return
//                            high before it looks for another start bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  T_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  T_V0      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  T_V1      = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  T_V2      = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
            DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_rx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input synchroniser and start-edge detect
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;
    logic rx_s_q;

    // NOTE: the synchroniser resets to the idle line level (1), so that
    // reset release is not mistaken for a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_q  <= rx_s;
        end
    end

    logic start_edge;
    assign start_edge = rx_s_q & ~rx_s;

    // ------------------------------------------------------------------
    // Frame datapath signals
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 v0;
    logic                 v1;
    logic [DATA_BITS-1:0] data_shift;
    logic                 par_bit;
    logic                 all_zero;
    logic                 stop_err;

    logic tick;
    logic vote;
    logic par_xor;
    logic par_bad;
    logic line_zero;
    logic frame_bad;

    assign tick = (div_cnt == DIV_LAST);

    // The third sample is the live rx_s value at the last voting tick.
    assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

    // The XOR over the data and the received parity bit is 0 for correct
    // even parity and 1 for correct odd parity.
    assign par_xor = (^data_shift) ^ par_bit;
    assign par_bad = (PARITY == 2) ? par_xor :
                     (PARITY == 1) ? ~par_xor : 1'b0;

    // These two signals are evaluated at the last stop-bit vote.
    assign line_zero = all_zero & ~vote;
    assign frame_bad = stop_err | ~vote;

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Receiver FSM, datapath and registered outputs
    // ------------------------------------------------------------------
    // NOTE: all state in this block uses non-blocking assignment. A later
    // assignment in the same cycle overrides an earlier default. The
    // delivery path relies on this to override the handshake clear of
    // data_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            data_shift  <= '0;
            par_bit     <= 1'b0;
            all_zero    <= 1'b0;
            stop_err    <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_START;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        all_zero <= 1'b1;
                        stop_err <= 1'b0;
                    end
                end

                // A frame of all zeros means the line is held low. Stay here
                // until the line returns high so that one break is not seen
                // as a stream of frames.
                S_BRK_WAIT: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    if (tick) begin
                        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
                        if (tick_cnt == T_V0) v0 <= rx_s;
                        if (tick_cnt == T_V1) v1 <= rx_s;

                        if (tick_cnt == T_V2) begin
                            case (state)
                                S_START: begin
                                    state <= vote ? S_IDLE : S_DATA;
                                end

                                S_DATA: begin
                                    data_shift <= {vote, data_shift[DATA_BITS-1:1]};
                                    all_zero   <= all_zero & ~vote;
                                    if (bit_cnt == BIT_LAST) begin
                                        bit_cnt <= '0;
                                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                    end
                                end

                                S_PARITY: begin
                                    par_bit  <= vote;
                                    all_zero <= all_zero & ~vote;
                                    state    <= S_STOP;
                                end

                                S_STOP: begin
                                    if (stop_cnt != STOP_LAST) begin
                                        stop_cnt <= stop_cnt + 1'b1;
                                        stop_err <= stop_err | ~vote;
                                        all_zero <= all_zero & ~vote;
                                    end else begin
                                        // Leave at mid-bit so that a start bit
                                        // right after this stop bit is caught.
                                        state <= S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                                        if (line_zero) begin
                                            break_det <= 1'b1;
                                            state     <= S_BRK_WAIT;
                                        end else begin
                                            data_out    <= data_shift;
                                            parity_err  <= par_bad;
                                            framing_err <= frame_bad;
                                            data_valid  <= 1'b1;
                                            overrun_err <= data_valid & ~data_ready;
                                        end
`else
                                        data_out    <= data_shift;
                                        parity_err  <= par_bad;
                                        framing_err <= frame_bad;
                                        data_valid  <= 1'b1;
                                        overrun_err <= data_valid & ~data_ready;
                                        if (line_zero) begin
                                            state <= S_BRK_WAIT;
                                        end
`endif
                                    end
                                end

                                default: begin
                                    state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
